// File: rtl/hdmi_tmds_pkg.sv
// hdmi_tmds_pkg: shared definitions for the HDMI bit-slip search block.
//   - TMDS control-token constants and a token-match helper
//   - scan FSM state encoding
//   - SLIP_MAX: last slip visited by a sweep
package hdmi_tmds_pkg;

  localparam logic [9:0] TOK_0    = 10'h354;
  localparam logic [9:0] TOK_1    = 10'h0AB;
  localparam logic [9:0] TOK_2    = 10'h154;
  localparam logic [9:0] TOK_3    = 10'h2AB;
  localparam logic [3:0] SLIP_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_COMMIT,
    ST_MONITOR
  } scan_state_e;

  function automatic logic is_token(input logic [9:0] w);
    return (w == TOK_0) || (w == TOK_1) || (w == TOK_2) || (w == TOK_3);
  endfunction

endpackage

// File: rtl/hdmi_token_counter.sv
// hdmi_token_counter: per-channel TMDS control-token counter.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_word         : slipped 10-bit word
//   i_clear        : synchronous clear (wins over enable)
//   i_enable       : count token cycles
//   o_count        : saturating token count
// The token compare is registered, so the count lags the word by one
// cycle; the settle period in front of every window hides that lag.
module hdmi_token_counter
  import hdmi_tmds_pkg::*;
#(
  parameter int CNT_W = 17
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [9:0]       i_word,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_count
);

  logic             r_tok;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tok   <= 1'b0;
      r_count <= '0;
    end else begin
      r_tok <= is_token(i_word);
      if (i_clear)
        r_count <= '0;
      else if (i_enable && r_tok && (r_count != '1))
        r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hdmi_slip_scan.sv
// hdmi_slip_scan: bit-slip search controller for the HDMI RX path
// (pixel-clock domain). Sweeps the shared slip 0..9, counts control
// tokens per channel at each slip, then commits the best slip per channel.
//   i_pix_clk, i_reset_n         : clock, async active-low reset
//   i_start / i_abort            : sweep start / abandon pulses (abort wins)
//   i_r, i_g, i_b                : slipped words from the manual slip path
//   o_bitslip_r/g/b              : {1'b0, slip[3:0]} to the slip path
//   o_busy, o_done               : sweep in progress / one-cycle commit pulse
//   o_locked                     : {r,g,b} committed slip met THRESH
//   o_status                     : {busy,locked,scan_slip,best_r,best_g,best_b,rescan_cnt}
// Optional: define HDMISCAN_RESCAN_EN to add the MONITOR state, which keeps
// measuring at the committed slips and re-sweeps after two bad windows.
module hdmi_slip_scan
  import hdmi_tmds_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int WINDOW_LOG2   = 16,
  parameter int THRESH        = 64
) (
  input  logic        i_pix_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [9:0]  i_r,
  input  logic [9:0]  i_g,
  input  logic [9:0]  i_b,
  output logic [4:0]  o_bitslip_r,
  output logic [4:0]  o_bitslip_g,
  output logic [4:0]  o_bitslip_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [2:0]  o_locked,
  output logic [31:0] o_status
);

  localparam int NUM_CH = 3;
  localparam int CNT_W  = WINDOW_LOG2 + 1;
  localparam int TMR_W  = WINDOW_LOG2 + 1;
  localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'((2 ** WINDOW_LOG2) - 1);
  localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESH);

  scan_state_e                  r_state, w_state_nxt;
  logic [TMR_W-1:0]             r_tmr;
  logic [3:0]                   r_scan;
  logic [NUM_CH-1:0][9:0]       w_word;
  logic [NUM_CH-1:0][CNT_W-1:0] w_cnt, r_best_cnt;
  logic [NUM_CH-1:0][3:0]       r_best_slip, r_commit_slip, w_slip;
  logic [NUM_CH-1:0]            r_locked;
  logic                         w_sweep, w_win_end, w_rescan, w_cnt_clr, w_cnt_en;
  logic [11:0]                  w_rescan_cnt;

  // index 2 = r, 1 = g, 0 = b throughout
  assign w_word = {i_r, i_g, i_b};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    hdmi_token_counter #(.CNT_W(CNT_W)) u_cnt (
      .i_clk    (i_pix_clk),
      .i_rst_n  (i_reset_n),
      .i_word   (w_word[c]),
      .i_clear  (w_cnt_clr),
      .i_enable (w_cnt_en),
      .o_count  (w_cnt[c])
    );
  end

  // ---------------- FSM ----------------
  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep     = 1'b0;
    case (r_state)
      ST_IDLE:    w_sweep = i_start;
      ST_SETTLE:  if (r_tmr == SET_LAST) w_state_nxt = ST_MEASURE;
      ST_MEASURE: if (r_tmr == WIN_LAST) w_state_nxt = ST_EVAL;
      ST_EVAL:    w_state_nxt = (r_scan == SLIP_MAX) ? ST_COMMIT : ST_SETTLE;
      ST_COMMIT: begin
`ifdef HDMISCAN_RESCAN_EN
        w_state_nxt = ST_MONITOR;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      ST_MONITOR: w_sweep = i_start | w_rescan;
      default:    w_state_nxt = ST_IDLE;
    endcase
    if (w_sweep) w_state_nxt = ST_SETTLE;
    // abort overrides everything, including a same-cycle start
    if (i_abort) begin
      w_sweep     = 1'b0;
      w_state_nxt = ST_IDLE;
    end
  end

  // phase timer: restarts on every state change and on each monitor window
  assign w_win_end = (r_state == ST_MONITOR) && (r_tmr == WIN_LAST);

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      r_tmr <= '0;
    else if ((r_state == ST_IDLE) || (w_state_nxt != r_state) || w_win_end)
      r_tmr <= '0;
    else
      r_tmr <= r_tmr + 1'b1;
  end

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      r_scan <= '0;
    else if (w_sweep)
      r_scan <= '0;
    else if ((r_state == ST_EVAL) && (w_state_nxt == ST_SETTLE))
      r_scan <= r_scan + 4'd1;
  end

  // counters read zero through settle; COMMIT clear gives MONITOR a fresh window
  assign w_cnt_clr = (r_state == ST_SETTLE) || (r_state == ST_COMMIT) || w_win_end;
  assign w_cnt_en  = (r_state == ST_MEASURE) || (r_state == ST_MONITOR);

  // best tracking (strict > keeps the lower slip on ties) and commit
  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_best_cnt    <= '0;
      r_best_slip   <= '0;
      r_commit_slip <= '0;
      r_locked      <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_sweep) begin
          r_best_cnt[c]  <= '0;
          r_best_slip[c] <= '0;
        end else if ((r_state == ST_EVAL) && (w_cnt[c] > r_best_cnt[c])) begin
          r_best_cnt[c]  <= w_cnt[c];
          r_best_slip[c] <= r_scan;
        end
        if ((r_state == ST_COMMIT) && !i_abort) begin
          r_commit_slip[c] <= r_best_slip[c];
          r_locked[c]      <= (r_best_cnt[c] >= THR);
        end
      end
    end
  end

`ifdef HDMISCAN_RESCAN_EN
  logic        r_bad, w_any_bad;
  logic [11:0] r_rescan_cnt;

  always_comb begin
    w_any_bad = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (r_locked[c] && (w_cnt[c] < THR)) w_any_bad = 1'b1;
  end

  // r_bad remembers that the previous window was already bad
  assign w_rescan = w_win_end && w_any_bad && r_bad;

  always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bad        <= 1'b0;
      r_rescan_cnt <= '0;
    end else begin
      if (r_state != ST_MONITOR) r_bad <= 1'b0;
      else if (w_win_end)        r_bad <= w_any_bad;
      if (w_rescan && w_sweep && (r_rescan_cnt != 12'hFFF))
        r_rescan_cnt <= r_rescan_cnt + 12'd1;
    end
  end

  assign w_rescan_cnt = r_rescan_cnt;
`else
  assign w_rescan     = 1'b0;
  assign w_rescan_cnt = 12'h000;
`endif

  // ---------------- outputs ----------------
  assign o_busy   = (r_state == ST_SETTLE) || (r_state == ST_MEASURE) ||
                    (r_state == ST_EVAL)   || (r_state == ST_COMMIT);
  assign o_done   = (r_state == ST_COMMIT) && !i_abort;
  assign o_locked = r_locked;

  assign w_slip      = o_busy ? {NUM_CH{r_scan}} : r_commit_slip;
  assign o_bitslip_r = {1'b0, w_slip[2]};
  assign o_bitslip_g = {1'b0, w_slip[1]};
  assign o_bitslip_b = {1'b0, w_slip[0]};

  assign o_status = {o_busy, r_locked, r_scan, r_best_slip, w_rescan_cnt};

endmodule
